// File: rtl/vote_pkg.sv
// Shared constants and state encoding for the ballot collector.
// Combinational definitions only; no latency, no backpressure.
package vote_pkg;
  localparam int N_VOTERS_DEF = 7;
  localparam int ID_W_DEF     = 3;
  localparam logic [N_VOTERS_DEF-1:0] ALL_CAST = '1;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t OPEN  = 2'd1;
  localparam state_t CLOSE = 2'd2;
endpackage

// File: rtl/ballot_timer.sv
// Ballot window timer: counts enabled cycles; expire is high on the last window cycle.
// Expire is combinational from the count; no backpressure.
module ballot_timer #(
  parameter int TIMEOUT = 200,
  parameter int TMR_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      timer <= '0;
    end else if (en) begin
      timer <= timer + 1'b1;
    end
  end

  assign expire = en && (timer == LAST);
endmodule

// File: rtl/vote_collector.sv
// Collects one vote per voter in a timed window and emits the vector with a done pulse.
// Cast-to-mask latency 1 cycle; no backpressure, downstream must take done when it pulses.
module vote_collector
  import vote_pkg::*;
#(
  parameter int N_VOTERS = N_VOTERS_DEF,
  parameter int ID_W     = ID_W_DEF,
  parameter int TIMEOUT  = 200,
  parameter int TMR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cast,
  input  logic [ID_W-1:0]     voter_id,
  input  logic                choice,
  output logic [N_VOTERS-1:0] vote,
  output logic [N_VOTERS-1:0] cast_mask,
  output logic                busy,
  output logic                done,
  output logic                timed_out,
  output logic                dup_err,
  output logic                id_err
);
  state_t              state;
  logic                is_open;
  logic                id_ok;
  logic                already;
  logic                accept;
  logic                all_cast;
  logic                expire;
  logic [N_VOTERS-1:0] cast_oh;
  logic [N_VOTERS-1:0] acc_oh;

  assign is_open  = (state == OPEN);
  assign id_ok    = (int'(voter_id) < N_VOTERS);
  assign cast_oh  = id_ok ? ({{(N_VOTERS-1){1'b0}}, 1'b1} << voter_id) : '0;
  assign already  = |(cast_oh & cast_mask);
  assign accept   = is_open && cast && id_ok && !already;
  assign acc_oh   = accept ? cast_oh : '0;
  // The cast landing this cycle counts toward completion, even on the expiry cycle.
  assign all_cast = &(cast_mask | acc_oh);

  ballot_timer #(
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state == IDLE) && start),
    .en    (is_open),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vote      <= '0;
      cast_mask <= '0;
      timed_out <= 1'b0;
      dup_err   <= 1'b0;
      id_err    <= 1'b0;
    end else begin
      dup_err <= is_open && cast && id_ok && already;
      id_err  <= is_open && cast && !id_ok;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= OPEN;
            vote      <= '0;
            cast_mask <= '0;
            timed_out <= 1'b0;
          end
        end
        OPEN: begin
          if (accept) begin
            cast_mask <= cast_mask | cast_oh;
            vote      <= (vote & ~cast_oh) | (choice ? cast_oh : '0);
          end
          if (all_cast || expire) begin
            state     <= CLOSE;
            timed_out <= expire && !all_cast;
          end
        end
        CLOSE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = is_open;
  assign done = (state == CLOSE);
endmodule
